// File: rtl/pipe_stall_ctrl_if.sv
// Stall-controller bundle: hazard/multicycle requests in, stop bits and FSM status out.
// Latency: none, wires only.
// Backpressure: none; stall[] is the backpressure this bundle carries to the pipeline.
interface pipe_stall_ctrl_if #(
  parameter int STALL_W = 6
);
  logic               stallreq_id;
  logic               ex_mc_req;
  logic               flush;
  logic [STALL_W-1:0] stall;
  logic               mc_busy;
  logic               mc_done;
  logic [5:0]         mc_cnt;

  // Pipeline side: raises requests, consumes stop bits and status.
  modport master (
    output stallreq_id, ex_mc_req, flush,
    input  stall, mc_busy, mc_done, mc_cnt
  );

  // Controller side.
  modport slave (
    input  stallreq_id, ex_mc_req, flush,
    output stall, mc_busy, mc_done, mc_cnt
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: load-use stalls plus an IDLE/RUN/DONE multicycle-EX sequencer.
// Latency: stall is combinational; a multicycle op stops PC..EX for MC_CYCLES+1 cycles, mc_done the cycle after.
// Backpressure: never stops MEM/WB; flush overrides everything and drops any op in flight without mc_done.
module pipe_stall_ctrl #(
  parameter int MC_CYCLES = 32,
  parameter int STALL_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stall_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter load: the request cycle is stalled too, so RUN lasts MC_CYCLES cycles ending at 0.
  localparam logic [5:0] CNT_LOAD = 6'(MC_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [5:0]         mc_cnt_q, mc_cnt_d;
  logic [STALL_W-1:0] stall_d;

  // Next-state and counter: flush wins over everything; DONE always returns to IDLE.
  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    if (bus.flush) begin
      state_d  = ST_IDLE;
      mc_cnt_d = 6'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.ex_mc_req) begin
            state_d  = ST_RUN;
            mc_cnt_d = CNT_LOAD;
          end
        end
        ST_RUN: begin
          // ex_mc_req dropping here does not abort the operation.
          if (mc_cnt_q == 6'd0) begin
            state_d = ST_DONE;
          end else begin
            mc_cnt_d = mc_cnt_q - 6'd1;
          end
        end
        ST_DONE: begin
          // The finishing instruction is still in EX; its request is ignored.
          state_d = ST_IDLE;
        end
        default: begin
          state_d  = ST_IDLE;
          mc_cnt_d = 6'd0;
        end
      endcase
    end
  end

  // State and counter registers, cleared asynchronously so a reset mid-RUN discards the op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      mc_cnt_q <= 6'd0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  // Stop-bit decode, priority: reset/flush, multicycle (PC..EX), load-use (PC..ID).
  always_comb begin
    stall_d = '0;
    if (!rst || bus.flush) begin
      stall_d = '0;
    end else if ((state_q == ST_IDLE && bus.ex_mc_req) || state_q == ST_RUN) begin
      stall_d[3:0] = 4'b1111;
    end else if (bus.stallreq_id) begin
      stall_d[2:0] = 3'b111;
    end
  end

  assign bus.stall   = stall_d;
  assign bus.mc_busy = (state_q == ST_RUN);
  assign bus.mc_done = (state_q == ST_DONE);
  assign bus.mc_cnt  = mc_cnt_q;

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter MC_CYCLES, default 32, number of RUN cycles of a multicycle EX operation; legal range 2..63.
REQ-002 Parameter STALL_W, default 6, width of stall bus (the codebase StallBus width).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-005 stallreq_id  input  1  load-use hazard stall request from ID, level, valid every cycle.
REQ-006 ex_mc_req  input  1  EX holds a multicycle operation (div/mult), level, held until mc_done.
REQ-007 flush  input  1  synchronous pipeline flush, one-cycle pulse.
REQ-008 stall  output  STALL_W  per-stage stop bits: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB; 1=Stop.
REQ-009 mc_busy  output  1  high while the FSM is in RUN.
REQ-010 mc_done  output  1  one-cycle pulse: multicycle result valid in EX.
REQ-011 mc_cnt  output  6  remaining RUN cycles.

Function
REQ-012 FSM states SHALL be IDLE, RUN, DONE; encoding is free.
REQ-013 IDLE: ex_mc_req=1 and flush=0 -> RUN, mc_cnt loaded with MC_CYCLES-1; otherwise stay.
REQ-014 RUN: mc_cnt decrements by 1 per cycle; mc_cnt==0 -> DONE; mc_cnt never wraps below 0.
REQ-015 DONE: unconditional -> IDLE after one cycle; ex_mc_req ignored in DONE (same instruction leaving EX).
REQ-016 flush=1 in any state -> IDLE next cycle, mc_cnt=0, no mc_done pulse; flush overrides a simultaneous ex_mc_req.
REQ-017 mc_done SHALL be 1 exactly when state==DONE; mc_busy exactly when state==RUN (both registered-state decodes).
REQ-018 stall is combinational from state and inputs, priority highest first: flush=1 -> all 0; (IDLE and ex_mc_req) or RUN -> 6'b001111; stallreq_id=1 -> 6'b000111; else all 0.
REQ-019 Multicycle stall covers the request cycle plus every RUN cycle: exactly MC_CYCLES+1 consecutive stalled cycles; stall[3:0] drops in the DONE cycle.
REQ-020 stallreq_id during RUN is subsumed (001111 already stops ID); in DONE stallreq_id=1 gives 000111.
REQ-021 stall[5:4] SHALL always be 0 (MEM/WB never stopped by this block).
REQ-022 ex_mc_req deasserted during RUN does not abort; only flush or reset abort.

Reset
REQ-023 rst=0 asynchronously forces state=IDLE, mc_cnt=0, hence mc_busy=0, mc_done=0.
REQ-024 While rst=0, stall SHALL be all 0 regardless of inputs.
REQ-025 After rst rises, first edge behaves as IDLE; reset asserted mid-RUN discards the operation with no mc_done.

Verification (MC_CYCLES=4)
REQ-026 Reset then idle inputs -> stall=0, mc_busy=0, mc_done=0, mc_cnt=0 on every cycle.
REQ-027 ex_mc_req=1 at cycle 0 held -> stall=001111 cycles 0..4, mc_cnt 3,2,1,0 in cycles 1..4, mc_done=1 cycle 5 only, stall=0 cycle 5.
REQ-028 stallreq_id=1 for one cycle in IDLE -> stall=000111 that cycle only; FSM stays IDLE.
REQ-029 ex_mc_req start, flush=1 at cycle 2 -> stall=0 cycle 2, IDLE cycle 3, mc_done never asserted.
REQ-030 rst=0 asynchronously between edges during RUN -> mc_busy falls immediately, stall=0, no mc_done after release.
REQ-031 ex_mc_req and stallreq_id both 1 in IDLE -> stall=001111; DONE cycle with stallreq_id=1 -> stall=000111.
